// File: rtl/dcache_store_merge_if.sv
// rtl/dcache_store_merge_if.sv - store request / merged line bus for the write-combining store merger
// master drives stores and consumes lines; slave is the merger.
interface dcache_store_merge_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 26
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BE_W   = WORD_W / 8;
  localparam int LINE_W = WORD_W * WORDS;
  localparam int LBE_W  = LINE_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  req_offset;
  logic [BE_W-1:0]   req_strb;
  logic [WORD_W-1:0] req_word;
  logic [LINE_W-1:0] req_line;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [LINE_W-1:0] out_line;
  logic [LBE_W-1:0]  out_mask;
  logic              idle;

  modport master (
    output req_valid, req_tag, req_offset, req_strb, req_word, req_line, flush, out_ready,
    input  req_ready, out_valid, out_tag, out_line, out_mask, idle
  );

  modport slave (
    input  req_valid, req_tag, req_offset, req_strb, req_word, req_line, flush, out_ready,
    output req_ready, out_valid, out_tag, out_line, out_mask, idle
  );
endinterface

// File: rtl/dcache_store_merge.sv
// rtl/dcache_store_merge.sv - write-combining store merger holding one line buffer for the D-cache write port
// Optional idle auto-drain enabled by defining WC_TIMEOUT_EN.
module dcache_store_merge #(
  parameter int WORD_W  = 32,
  parameter int WORDS   = 4,
  parameter int TAG_W   = 26,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  dcache_store_merge_if.slave bus
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BE_W   = WORD_W / 8;
  localparam int LINE_W = WORD_W * WORDS;
  localparam int LBE_W  = LINE_W / 8;

  typedef enum logic [1:0] {EMPTY, HOLD, DRAIN} state_t;

  state_t state, state_nxt;
  logic   hit;
  logic   accept;

  function automatic logic [LINE_W-1:0] merge_line(
    input logic [LINE_W-1:0] base,
    input logic [OFF_W-1:0]  off,
    input logic [BE_W-1:0]   strb,
    input logic [WORD_W-1:0] word
  );
    logic [LINE_W-1:0] res;
    res = base;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < BE_W; b++) begin
        if (OFF_W'(w) == off && strb[b]) begin
          res[w*WORD_W + b*8 +: 8] = word[b*8 +: 8];
        end
      end
    end
    return res;
  endfunction

  function automatic logic [LBE_W-1:0] place_strb(
    input logic [OFF_W-1:0] off,
    input logic [BE_W-1:0]  strb
  );
    logic [LBE_W-1:0] m;
    m = '0;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < BE_W; b++) begin
        m[w*BE_W + b] = (OFF_W'(w) == off) && strb[b];
      end
    end
    return m;
  endfunction

`ifdef WC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;
  assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // The output registers double as the line buffer.
  assign hit = (bus.req_tag == bus.out_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    case (state)
      EMPTY: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        bus.req_ready = !(bus.req_valid && !hit);
        accept        = bus.req_valid && hit;
        // A same-cycle hit is merged before the flush drains the line.
        if ((bus.req_valid && !hit) || bus.flush) begin
          state_nxt = DRAIN;
`ifdef WC_TIMEOUT_EN
        end else if (!accept && timeout_hit) begin
          state_nxt = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_tag  <= '0;
      bus.out_line <= '0;
      bus.out_mask <= '0;
    end else if (accept) begin
      if (state == EMPTY) begin
        bus.out_tag  <= bus.req_tag;
        bus.out_line <= merge_line(bus.req_line, bus.req_offset, bus.req_strb, bus.req_word);
        bus.out_mask <= place_strb(bus.req_offset, bus.req_strb);
      end else begin
        bus.out_line <= merge_line(bus.out_line, bus.req_offset, bus.req_strb, bus.req_word);
        bus.out_mask <= bus.out_mask | place_strb(bus.req_offset, bus.req_strb);
      end
    end else if (state == DRAIN && bus.out_ready) begin
      bus.out_mask <= '0;
    end
  end

`ifdef WC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state == HOLD && !accept && state_nxt == HOLD) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`endif

  assign bus.out_valid = (state == DRAIN);
  assign bus.idle      = (state == EMPTY);
endmodule

// File: tb/tb_dcache_store_merge.sv
// tb/tb_dcache_store_merge.sv - scoreboard bench for dcache_store_merge with a line-level reference model
module tb_dcache_store_merge;
  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int TAG_W   = 26;
  localparam int TIMEOUT = 16;
  localparam int OFF_W   = 2;
  localparam int BE_W    = 4;
  localparam int LINE_W  = 128;
  localparam int LBE_W   = 16;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
    logic [LBE_W-1:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_store_merge_if #(.WORD_W(WORD_W), .WORDS(WORDS), .TAG_W(TAG_W)) bus ();

  dcache_store_merge #(
    .WORD_W(WORD_W), .WORDS(WORDS), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: one open line kept as plain values, bytes written one at a time.
  bit                m_open = 1'b0;
  logic [TAG_W-1:0]  m_tag;
  logic [LINE_W-1:0] m_line;
  logic [LBE_W-1:0]  m_mask;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [OFF_W-1:0] off, input logic [BE_W-1:0] strb, input logic [WORD_W-1:0] word);
    for (int b = 0; b < BE_W; b++) begin
      if (strb[b]) begin
        m_line[(int'(off) * BE_W + b) * 8 +: 8] = word[b*8 +: 8];
        m_mask[int'(off) * BE_W + b] = 1'b1;
      end
    end
  endtask

  task automatic close_line();
    exp_t e;
    if (m_open) begin
      e.tag  = m_tag;
      e.line = m_line;
      e.mask = m_mask;
      exp_q.push_back(e);
      m_open = 1'b0;
    end
  endtask

  task automatic do_store(input logic [TAG_W-1:0] tag, input logic [OFF_W-1:0] off, input logic [BE_W-1:0] strb,
                          input logic [WORD_W-1:0] word, input logic [LINE_W-1:0] line, input bit with_flush);
    int stalls;
    int exp_stalls;
    bit done;
    stalls = 0;
    done = 1'b0;
    exp_stalls = (m_open && tag != m_tag) ? 2 : 0;
    if (m_open && tag != m_tag) close_line();
    bus.req_valid  = 1'b1;
    bus.req_tag    = tag;
    bus.req_offset = off;
    bus.req_strb   = strb;
    bus.req_word   = word;
    bus.req_line   = line;
    bus.flush      = with_flush;
    while (!done && stalls < 20) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1'b1;
        if (!m_open) begin
          m_open = 1'b1;
          m_tag  = tag;
          m_line = line;
          m_mask = '0;
        end
        model_write(off, strb, word);
        if (with_flush) close_line();
      end else begin
        stalls++;
      end
      step();
      bus.flush = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("store_accepted", LINE_W'(done), LINE_W'(1));
    check("store_stalls", LINE_W'(stalls), LINE_W'(exp_stalls));
    if (with_flush) step();
  endtask

  // Ends at the negedge of the cycle after flush was sampled; caller steps on.
  task automatic do_flush();
    bit was_open;
    was_open = m_open;
    bus.flush = 1'b1;
    close_line();
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", LINE_W'(bus.out_valid), LINE_W'(was_open));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", LINE_W'(1), LINE_W'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_tag", LINE_W'(bus.out_tag), LINE_W'(e.tag));
        check("out_line", bus.out_line, e.line);
        check("out_mask", LINE_W'(bus.out_mask), LINE_W'(e.mask));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t bp;
    logic [LINE_W-1:0] rl;
    int   n;
    bit   saw;
    int   r;

    bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_offset = '0; bus.req_strb = '0;
    bus.req_word = '0; bus.req_line = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    #2;
    check("rst_out_valid", LINE_W'(bus.out_valid), LINE_W'(0));
    check("rst_idle", LINE_W'(bus.idle), LINE_W'(1));
    check("rst_req_ready", LINE_W'(bus.req_ready), LINE_W'(1));
    check("rst_out_line", bus.out_line, LINE_W'(0));
    check("rst_out_mask", LINE_W'(bus.out_mask), LINE_W'(0));
    check("rst_out_tag", LINE_W'(bus.out_tag), LINE_W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Open and flush
    do_store(26'h10, 2'd2, 4'b0011, 32'hAABBCCDD, 128'h33333333_22222222_11111111_00000000, 1'b0);
    do_flush();
    check("of_line", bus.out_line, 128'h33333333_2222CCDD_11111111_00000000);
    check("of_mask", LINE_W'(bus.out_mask), LINE_W'(16'h0300));
    check("of_tag", LINE_W'(bus.out_tag), LINE_W'(26'h10));
    step();

    // Combining
    rl = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 4; i++) do_store(26'h10, OFF_W'(i), 4'hF, 32'(i), rl, 1'b0);
    do_flush();
    check("comb_line", bus.out_line, 128'h00000003_00000002_00000001_00000000);
    check("comb_mask", LINE_W'(bus.out_mask), LINE_W'(16'hFFFF));
    step();

    // Miss eviction
    do_store(26'h10, 2'd1, 4'hF, 32'h12345678, rl, 1'b0);
    do_store(26'h20, 2'd0, 4'h1, 32'h00000099, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
    @(negedge clk);
    check("miss_new_tag", LINE_W'(bus.out_tag), LINE_W'(26'h20));
    check("miss_new_line", bus.out_line, 128'hDEADBEEF_CAFEF00D_01234567_89ABCD99);
    check("miss_new_mask", LINE_W'(bus.out_mask), LINE_W'(16'h0001));
    step();
    do_flush();
    step();

    // Backpressure
    do_store(26'h30, 2'd3, 4'hA, 32'h5A5A5A5A, rl, 1'b0);
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    close_line();
    bp = exp_q[$];
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", LINE_W'(bus.out_valid), LINE_W'(1));
      check("bp_req_ready", LINE_W'(bus.req_ready), LINE_W'(0));
      check("bp_line", bus.out_line, bp.line);
      check("bp_mask", LINE_W'(bus.out_mask), LINE_W'(bp.mask));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_exit_idle", LINE_W'(bus.idle), LINE_W'(1));
    step();

    // Idle behaviour
    do_store(26'h40, 2'd0, 4'hF, 32'hFEEDFACE, rl, 1'b0);
`ifdef WC_TIMEOUT_EN
    close_line();
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", LINE_W'(n), LINE_W'(TIMEOUT));
    step();
`else
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.out_valid) saw = 1'b1;
    end
    check("no_timeout", LINE_W'(saw), LINE_W'(0));
    do_flush();
    step();
`endif

    // Reset mid-HOLD discards the line
    do_store(26'h50, 2'd1, 4'hF, 32'h01020304, rl, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rh_out_valid", LINE_W'(bus.out_valid), LINE_W'(0));
    check("rh_idle", LINE_W'(bus.idle), LINE_W'(1));
    check("rh_req_ready", LINE_W'(bus.req_ready), LINE_W'(1));
    m_open = 1'b0;
    step();
    rst = 1'b0;

    // Reset mid-DRAIN discards the line
    do_store(26'h60, 2'd2, 4'hF, 32'h0A0B0C0D, rl, 1'b0);
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("rd_valid", LINE_W'(bus.out_valid), LINE_W'(1));
    #2 rst = 1'b1;
    #1;
    check("rd_out_valid", LINE_W'(bus.out_valid), LINE_W'(0));
    m_open = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("rd_idle", LINE_W'(bus.idle), LINE_W'(1));

    // Randomized traffic over a few tags
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        do_store(26'h100 + 26'($urandom_range(0, 2)), OFF_W'($urandom_range(0, 3)), BE_W'($urandom_range(0, 15)),
                 $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
      end else if (r < 8 && m_open) begin
        do_store(m_tag, OFF_W'($urandom_range(0, 3)), BE_W'($urandom_range(0, 15)),
                 $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      end else begin
        do_flush();
        step();
      end
    end
    do_flush();
    step();

    repeat (3) step();
    check("queue_empty", LINE_W'(exp_q.size()), LINE_W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
